// File: rtl/pattern_pkg.sv
// Purpose: shared types for the pattern checker (word width, field layouts, lock states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pattern_pkg;

    localparam int PW = 5;

    // Layout 0: narrow a in the MSBs, wide b below it.
    typedef struct packed {
        logic [1:0] a;
        logic [2:0] b;
    } struct_1_t;

    // Layout 1: wide a in the MSBs, narrow b below it.
    typedef struct packed {
        logic [2:0] a;
        logic [1:0] b;
    } struct_2_t;

    typedef enum logic {LAYOUT_S1, LAYOUT_S2} layout_e;

    typedef enum logic {SEARCH, LOCKED} lock_state_e;

    // Default reference word: a all ones, b all zeros (5'b11000).
    localparam struct_1_t EXPECT_DEFAULT = '{a: '1, b: '0};

endpackage

// File: rtl/pattern_fifo.sv
// Purpose: small synchronous FIFO buffering pattern words ahead of the checker.
// Latency: a word pushed at edge N is visible on rdata after edge N; no push-to-pop bypass.
// Backpressure: push is ignored while full (even with a same-cycle pop); pop ignored while empty.
// Ports: clk/rst (sync, active-high), push/wdata in, pop, rdata = head slot, full/empty flags.
module pattern_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !rst;
    assign do_pop  = pop && !empty;
    // Head slot is always driven, even when empty (stale data is don't-care then).
    assign rdata   = mem[rptr];

    // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/pattern_stream_checker.sv
// Purpose: buffer pattern words, decode the head under LAYOUT, compare to EXPECT, count and lock.
// Latency: in_data reaches out_* one cycle after it is accepted; locked follows the deciding pop by one cycle.
// Backpressure: in_ready = !full (low during rst); the head is held until out_ready.
// Ports: clk/rst; in_valid/in_data/in_ready upstream; out_valid/out_ready/out_a/out_b/out_match head;
//        match_cnt/mismatch_cnt saturating pop counters; locked from the lock FSM.
module pattern_stream_checker
    import pattern_pkg::*;
#(
    parameter int        LAYOUT = 0,
    parameter struct_1_t EXPECT = EXPECT_DEFAULT,
    parameter int        DEPTH  = 4,
    parameter int        LOCK_N = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_a,
    output logic [2:0]    out_b,
    output logic          out_match,
    output logic [7:0]    match_cnt,
    output logic [7:0]    mismatch_cnt,
    output logic          locked
);

    localparam int CNTW = $clog2(LOCK_N + 1);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [PW-1:0] head;

    lock_state_e   state_q, state_d;
    logic [CNTW-1:0] cons_q, cons_d;

    assign in_ready  = !full && !rst;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    pattern_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Field decode: reinterpret the head word under the selected struct layout.
    if (LAYOUT == int'(LAYOUT_S2)) begin : g_layout_s2
        struct_2_t hs;
        assign hs    = struct_2_t'(head);
        assign out_a = hs.a;
        assign out_b = {1'b0, hs.b};
    end else begin : g_layout_s1
        struct_1_t hs;
        assign hs    = struct_1_t'(head);
        assign out_a = {1'b0, hs.a};
        assign out_b = hs.b;
    end

    // Whole-word compare, deliberately independent of LAYOUT.
    assign out_match = (head == PW'(EXPECT));

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
        end else if (pop) begin
            if (out_match) begin
                if (match_cnt != 8'hFF) match_cnt <= match_cnt + 8'd1;
            end else begin
                if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            cons_q  <= '0;
        end else begin
            state_q <= state_d;
            cons_q  <= cons_d;
        end
    end

    // Lock FSM only advances on a pop; any mismatch drops back to SEARCH with a clean run.
    always_comb begin
        state_d = state_q;
        cons_d  = cons_q;
        if (pop) begin
            if (!out_match) begin
                state_d = SEARCH;
                cons_d  = '0;
            end else if (state_q == SEARCH) begin
                if (cons_q < CNTW'(LOCK_N)) cons_d = cons_q + CNTW'(1);
                // Lock in the same update that completes the run.
                if (cons_d == CNTW'(LOCK_N)) state_d = LOCKED;
            end
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_pattern_stream_checker.sv
module tb_pattern_stream_checker;

    localparam logic [4:0] EXP    = 5'b11000;
    localparam int         DEPTH  = 4;
    localparam int         LOCK_N = 3;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_data;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_match0, locked0;
    logic [2:0] out_a0, out_b0;
    logic [7:0] match_cnt0, mismatch_cnt0;

    logic       in_ready1, out_valid1, out_match1, locked1;
    logic [2:0] out_a1, out_b1;
    logic [7:0] match_cnt1, mismatch_cnt1;

    int tests = 0;
    int fails = 0;

    pattern_stream_checker #(.LAYOUT(0), .DEPTH(DEPTH), .LOCK_N(LOCK_N)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_a(out_a0), .out_b(out_b0),
        .out_match(out_match0), .match_cnt(match_cnt0), .mismatch_cnt(mismatch_cnt0),
        .locked(locked0)
    );

    pattern_stream_checker #(.LAYOUT(1), .DEPTH(DEPTH), .LOCK_N(LOCK_N)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_a(out_a1), .out_b(out_b1),
        .out_match(out_match1), .match_cnt(match_cnt1), .mismatch_cnt(mismatch_cnt1),
        .locked(locked1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference model: a queue of buffered words plus counters and a lock flag.
    logic [4:0] q[$];
    int         m_match, m_mis, m_cons;
    bit         m_locked;
    bit         model_on = 1'b0;
    bit         m_push, m_pop;
    logic [4:0] m_head;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_match  = 0;
            m_mis    = 0;
            m_cons   = 0;
            m_locked = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = out_ready && (q.size() > 0);
            if (m_pop) begin
                m_head = q.pop_front();
                if (m_head == EXP) begin
                    if (m_match < 255) m_match++;
                    if (!m_locked) begin
                        if (m_cons < LOCK_N) m_cons++;
                        if (m_cons == LOCK_N) m_locked = 1'b1;
                    end
                end else begin
                    if (m_mis < 255) m_mis++;
                    m_cons   = 0;
                    m_locked = 1'b0;
                end
            end
            if (m_push) q.push_back(in_data);
        end
    end

    logic [4:0] c_head;
    always @(negedge clk) begin
        if (model_on) begin
            chk("in_ready", int'(in_ready0), int'(!rst && q.size() < DEPTH));
            chk("in_ready_l1", int'(in_ready1), int'(!rst && q.size() < DEPTH));
            chk("out_valid", int'(out_valid0), int'(q.size() > 0));
            chk("out_valid_l1", int'(out_valid1), int'(q.size() > 0));
            if (q.size() > 0) begin
                c_head = q[0];
                chk("out_a_l0", int'(out_a0), int'(c_head) >> 3);
                chk("out_b_l0", int'(out_b0), int'(c_head) & 7);
                chk("out_a_l1", int'(out_a1), int'(c_head) >> 2);
                chk("out_b_l1", int'(out_b1), int'(c_head) & 3);
                chk("out_match", int'(out_match0), int'(c_head == EXP));
                chk("out_match_l1", int'(out_match1), int'(c_head == EXP));
            end
            chk("match_cnt", int'(match_cnt0), m_match);
            chk("mismatch_cnt", int'(mismatch_cnt0), m_mis);
            chk("locked", int'(locked0), int'(m_locked));
            chk("match_cnt_l1", int'(match_cnt1), m_match);
            chk("locked_l1", int'(locked1), int'(m_locked));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        // Idle after reset.
        chk("rst_in_ready", int'(in_ready0), 1);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_match_cnt", int'(match_cnt0), 0);
        chk("rst_mismatch_cnt", int'(mismatch_cnt0), 0);
        chk("rst_locked", int'(locked0), 0);

        // Single expected word, both layouts decoded.
        in_valid = 1'b1; in_data = EXP;
        tick();
        in_valid = 1'b0;
        chk("lat_out_valid", int'(out_valid0), 1);
        chk("dec_a_l0", int'(out_a0), 3);
        chk("dec_b_l0", int'(out_b0), 0);
        chk("dec_match", int'(out_match0), 1);
        chk("dec_a_l1", int'(out_a1), 6);
        chk("dec_b_l1", int'(out_b1), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_match", int'(match_cnt0), 1);

        // Fill to full with 1..4, 5th held until space opens.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 5'(i);
            tick();
        end
        chk("full_in_ready", int'(in_ready0), 0);
        in_data = 5'd5; out_ready = 1'b1;
        tick();                     // pops 1, full so 5 is not taken
        chk("head_after_pop1", int'(out_b0), 2);
        tick();                     // pops 2, accepts 5
        in_valid = 1'b0;
        tick(); tick();             // pops 3, 4
        chk("mis_after_4", int'(mismatch_cnt0), 4);
        chk("held_word_head", int'(out_b0), 5);
        tick();                     // pops 5
        out_ready = 1'b0;
        chk("mis_after_5", int'(mismatch_cnt0), 5);
        chk("drained", int'(out_valid0), 0);

        // Lock sequence: EXP x3 -> lock, 00001 -> unlock, EXP x2 -> still unlocked.
        out_ready = 1'b1; in_valid = 1'b1; in_data = EXP;
        tick(); tick(); tick();
        chk("pre_lock", int'(locked0), 0);
        in_data = 5'b00001;
        tick();
        chk("lock", int'(locked0), 1);
        in_data = EXP;
        tick();
        chk("unlock", int'(locked0), 0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("relock_short", int'(locked0), 0);

        // Steady push+pop at occupancy 2 across pointer wrap.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 5'($urandom); tick();
        in_data = 5'($urandom); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 5'($urandom);
            tick();
            chk("wrap_valid", int'(out_valid0), 1);
            chk("wrap_ready", int'(in_ready0), 1);
        end
        in_valid = 1'b0;
        tick(); tick(); tick();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = ($urandom_range(0, 1) != 0) ? EXP : 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();

        // Mid-stream reset with 3 words buffered.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 5'($urandom);
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst_hold_in_ready", int'(in_ready0), 0);
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", int'(out_valid0), 0);
        chk("midrst_match", int'(match_cnt0), 0);
        chk("midrst_mismatch", int'(mismatch_cnt0), 0);
        chk("midrst_locked", int'(locked0), 0);

        // Saturation: over 300 matching pops.
        in_valid = 1'b1; in_data = EXP; out_ready = 1'b1;
        repeat (305) tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("sat_match", int'(match_cnt0), 255);
        chk("sat_mismatch", int'(mismatch_cnt0), 0);
        chk("sat_locked", int'(locked0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
